// File: rtl/icache_axi_refill_if.sv
// Bus bundle between the ICache refill port, the refill responder and the
// AXI instruction-read master slot. The responder uses the master modport.
interface icache_axi_refill_if;
    // ICache line-read port
    logic         mem_inst_ren_i;
    logic [31:0]  mem_inst_araddr_i;
    logic         mem_inst_rvalid_o;
    logic [255:0] mem_inst_rdata_o;
    // AXI read-address channel
    logic [3:0]   arid;
    logic [31:0]  araddr;
    logic [7:0]   arlen;
    logic [2:0]   arsize;
    logic [1:0]   arburst;
    logic         arvalid;
    logic         arready;
    // AXI read-data channel
    logic [3:0]   rid;
    logic [31:0]  rdata;
    logic [1:0]   rresp;
    logic         rlast;
    logic         rvalid;
    logic         rready;

    modport master (
        input  mem_inst_ren_i, mem_inst_araddr_i,
        output mem_inst_rvalid_o, mem_inst_rdata_o,
        output arid, araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        output mem_inst_ren_i, mem_inst_araddr_i,
        input  mem_inst_rvalid_o, mem_inst_rdata_o,
        input  arid, araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );
endinterface

// File: rtl/icache_axi_refill.sv
// ICache line-refill responder: turns a level-held line-read request into a
// single 8-beat AXI4 INCR burst, assembles the beats into a 256-bit line and
// returns it with a one-cycle valid pulse. A request that is withdrawn or
// retargeted while the burst is in flight is marked cancelled; the burst is
// still drained (AXI cannot abort it) but no line is returned.
module icache_axi_refill #(
    parameter logic [3:0] AXI_ID = 4'h0,
    parameter int         BEATS  = 8
) (
    input  logic                clk,
    input  logic                rst,
    icache_axi_refill_if.master bus
);

    localparam int         CNT_W   = $clog2(BEATS);
    localparam logic [7:0] ARLEN_C = 8'(BEATS - 32'sd1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        AR   = 2'b01,
        R    = 2'b10,
        RESP = 2'b11
    } state_t;

    state_t                 state_r;
    state_t                 state_d;
    logic                   arvalid_r;
    logic                   arvalid_d;
    logic                   rready_r;
    logic                   rready_d;
    logic                   pulse_r;
    logic                   pulse_d;
    logic                   cancel_r;
    logic                   cancel_d;
    logic [31:0]            line_addr_r;
    logic [31:0]            line_addr_d;
    logic [CNT_W-1:0]       beat_r;
    logic [CNT_W-1:0]       beat_d;
    logic [BEATS*32-1:0]    line_buf_r;
    logic                   beat_we_s;
    logic                   mismatch_s;
    logic                   unused_ok_s;

    // The request no longer describes the line being fetched.
    assign mismatch_s = (~bus.mem_inst_ren_i) |
                        (bus.mem_inst_araddr_i[31:5] != line_addr_r[31:5]);

    // Next-state and next-output decode for the refill sequence.
    always_comb begin
        state_d     = state_r;
        arvalid_d   = arvalid_r;
        rready_d    = rready_r;
        pulse_d     = 1'b0;
        cancel_d    = cancel_r;
        line_addr_d = line_addr_r;
        beat_d      = beat_r;
        beat_we_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.mem_inst_ren_i) begin
                    line_addr_d = {bus.mem_inst_araddr_i[31:5], 5'b00000};
                    cancel_d    = 1'b0;
                    beat_d      = '0;
                    arvalid_d   = 1'b1;
                    state_d     = AR;
                end else begin
                    state_d = IDLE;
                end
            end
            AR: begin
                cancel_d = cancel_r | mismatch_s;
                if (arvalid_r && bus.arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = R;
                end else begin
                    state_d = AR;
                end
            end
            R: begin
                cancel_d = cancel_r | mismatch_s;
                if (bus.rvalid) begin
                    beat_we_s = 1'b1;
                    beat_d    = beat_r + CNT_W'(1);
                    // rlast, not the beat counter, closes the burst
                    if (bus.rlast) begin
                        rready_d = 1'b0;
                        pulse_d  = ~(cancel_r | mismatch_s);
                        state_d  = RESP;
                    end else begin
                        state_d = R;
                    end
                end else begin
                    state_d = R;
                end
            end
            RESP: begin
                // no relaunch here: the ICache only drops ren on seeing the pulse
                state_d = IDLE;
            end
            default: begin
                state_d   = IDLE;
                arvalid_d = 1'b0;
                rready_d  = 1'b0;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_d;
        end
    end

    // Registered handshake outputs, request address and bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            arvalid_r   <= 1'b0;
            rready_r    <= 1'b0;
            pulse_r     <= 1'b0;
            cancel_r    <= 1'b0;
            line_addr_r <= 32'h0000_0000;
            beat_r      <= '0;
        end else begin
            arvalid_r   <= arvalid_d;
            rready_r    <= rready_d;
            pulse_r     <= pulse_d;
            cancel_r    <= cancel_d;
            line_addr_r <= line_addr_d;
            beat_r      <= beat_d;
        end
    end

    // Line buffer: each accepted beat lands in the slot named by the beat counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            line_buf_r <= '0;
        end else if (beat_we_s) begin
            line_buf_r[int'(beat_r) * 32 +: 32] <= bus.rdata;
        end else begin
            line_buf_r <= line_buf_r;
        end
    end

    assign bus.arid              = AXI_ID;
    assign bus.araddr            = line_addr_r;
    assign bus.arlen             = ARLEN_C;
    assign bus.arsize            = 3'b010;
    assign bus.arburst           = 2'b01;
    assign bus.arvalid           = arvalid_r;
    assign bus.rready            = rready_r;
    assign bus.mem_inst_rvalid_o = pulse_r;
    assign bus.mem_inst_rdata_o  = line_buf_r;

    // rid/rresp are deliberately ignored and the in-line offset is don't-care.
    assign unused_ok_s = ^{bus.rid, bus.rresp, bus.mem_inst_araddr_i[4:0]};

endmodule

// File: tb/tb_icache_axi_refill.sv
// Bench for icache_axi_refill: an AXI slave with programmable AR delay, beat
// gaps and burst length, an ICache-side requester, and a transaction-level
// model checked against the DUT on every cycle, plus literal expectations.
module tb_icache_axi_refill;

    logic clk;
    logic rst;

    icache_axi_refill_if bus ();

    icache_axi_refill #(.AXI_ID(4'h0), .BEATS(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // slave configuration
    int cfg_ar_wait = 0;
    int cfg_gap [8];
    int cfg_nbeats  = 8;
    int cfg_pattern = 0;

    // model state: what the DUT outputs must be in the current cycle
    logic         m_busy, m_cool, m_arvalid, m_rready, m_pulse, m_clean;
    logic [31:0]  m_araddr;
    int           m_beat;
    logic [31:0]  m_line [8];
    logic [255:0] m_line_flat;
    logic         m_clean_now;
    int           dut_beats = 0;

    // monitors
    int           ar_rises = 0;
    int           ar_rise_cyc = 0;
    logic [31:0]  ar_addr_last = 32'h0;
    int           pulses = 0;

    task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    assign m_line_flat = {m_line[7], m_line[6], m_line[5], m_line[4],
                          m_line[3], m_line[2], m_line[1], m_line[0]};
    assign m_clean_now = m_clean && bus.mem_inst_ren_i &&
                         (bus.mem_inst_araddr_i[31:5] == m_araddr[31:5]);

    // Transaction-level reference: one request in flight, address phase then
    // data phase, line returned only if the request stayed unchanged throughout.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy <= 1'b0; m_cool <= 1'b0; m_arvalid <= 1'b0; m_rready <= 1'b0;
            m_pulse <= 1'b0; m_clean <= 1'b0; m_araddr <= 32'h0; m_beat <= 0;
            for (int i = 0; i < 8; i++) m_line[i] <= 32'h0;
        end else begin
            dut_beats <= dut_beats + ((bus.rvalid && bus.rready) ? 1 : 0);
            m_pulse <= 1'b0;
            m_cool  <= 1'b0;
            if (!m_busy) begin
                if (!m_cool && bus.mem_inst_ren_i) begin
                    m_busy    <= 1'b1;
                    m_arvalid <= 1'b1;
                    m_araddr  <= {bus.mem_inst_araddr_i[31:5], 5'b00000};
                    m_beat    <= 0;
                    m_clean   <= 1'b1;
                end
            end else begin
                m_clean <= m_clean_now;
                if (m_arvalid) begin
                    if (bus.arready) begin
                        m_arvalid <= 1'b0;
                        m_rready  <= 1'b1;
                    end
                end else if (m_rready && bus.rvalid) begin
                    m_line[m_beat] <= bus.rdata;
                    m_beat <= (m_beat + 1) % 8;
                    if (bus.rlast) begin
                        m_rready <= 1'b0;
                        m_busy   <= 1'b0;
                        m_cool   <= 1'b1;
                        m_pulse  <= m_clean_now;
                    end
                end
            end
        end
    end

    // Per-cycle comparison of DUT outputs against the model, plus monitors.
    initial begin
        logic prev_arv;
        prev_arv = 1'b0;
        forever begin
            @(negedge clk);
            check("arvalid",  {255'd0, bus.arvalid}, {255'd0, m_arvalid});
            check("rready",   {255'd0, bus.rready},  {255'd0, m_rready});
            check("rvalid_o", {255'd0, bus.mem_inst_rvalid_o}, {255'd0, m_pulse});
            check("rdata_o",  bus.mem_inst_rdata_o, m_line_flat);
            if (m_arvalid) begin
                check("araddr",  {224'd0, bus.araddr},  {224'd0, m_araddr});
                check("arlen",   {248'd0, bus.arlen},   {248'd0, 8'd7});
                check("arsize",  {253'd0, bus.arsize},  {253'd0, 3'b010});
                check("arburst", {254'd0, bus.arburst}, {254'd0, 2'b01});
                check("arid",    {252'd0, bus.arid},    {252'd0, 4'h0});
            end
            if (bus.arvalid && !prev_arv) begin
                ar_rises++;
                ar_rise_cyc  = cyc;
                ar_addr_last = bus.araddr;
            end
            prev_arv = bus.arvalid;
            if (bus.mem_inst_rvalid_o) pulses++;
        end
    end

    // AXI slave: AR delay, then the configured beat schedule with bubbles.
    initial begin
        int          s_phase;
        int          s_wait;
        int          sched[$];
        logic [31:0] s_addr;
        int          e;
        s_phase = 0; s_wait = 0; s_addr = 32'h0;
        bus.arready = 1'b0; bus.rvalid = 1'b0; bus.rlast = 1'b0;
        bus.rdata = 32'h0; bus.rid = 4'h0; bus.rresp = 2'b00;
        forever begin
            @(negedge clk);
            bus.rid   = 4'($urandom);
            bus.rresp = 2'($urandom);
            if (rst) begin
                s_phase = 0; s_wait = 0; sched.delete();
                bus.arready = 1'b0; bus.rvalid = 1'b0; bus.rlast = 1'b0;
            end else if (s_phase == 0) begin
                bus.rvalid = 1'b0; bus.rlast = 1'b0; bus.rdata = $urandom;
                if (bus.arready) begin
                    bus.arready = 1'b0;
                    s_phase = 1;
                    for (int i = 0; i < cfg_nbeats; i++) begin
                        sched.push_back(i);
                        for (int g = 0; g < cfg_gap[i]; g++) sched.push_back(-1);
                    end
                end else if (bus.arvalid) begin
                    if (s_wait >= cfg_ar_wait) begin
                        bus.arready = 1'b1;
                        s_addr = bus.araddr;
                    end else begin
                        s_wait++;
                    end
                end
            end
            if (!rst && s_phase == 1) begin
                if (sched.size() == 0) begin
                    bus.rvalid = 1'b0; bus.rlast = 1'b0; bus.rdata = $urandom;
                    s_phase = 0; s_wait = 0;
                end else begin
                    e = sched.pop_front();
                    if (e < 0) begin
                        bus.rvalid = 1'b0; bus.rlast = 1'b0; bus.rdata = $urandom;
                    end else begin
                        bus.rvalid = 1'b1;
                        bus.rlast  = (e == cfg_nbeats - 1);
                        if (cfg_pattern == 0)      bus.rdata = 32'h1111_1111 * 32'(e + 1);
                        else if (cfg_pattern == 2) bus.rdata = s_addr + 32'(4 * e);
                        else                       bus.rdata = $urandom;
                    end
                end
            end
        end
    end

    // One ICache request: optional drop or address change at a relative cycle.
    task automatic do_req(input logic [31:0] a, input int drop_at, input int chg_at,
                          input logic [31:0] a2, output int t0, output int tp,
                          output logic [255:0] pd);
        logic dropped, done;
        @(negedge clk);
        bus.mem_inst_ren_i = 1'b1;
        bus.mem_inst_araddr_i = a;
        t0 = cyc; tp = -1; pd = '0; dropped = 1'b0; done = 1'b0;
        for (int k = 0; k < 300 && !done; k++) begin
            @(negedge clk);
            if (bus.mem_inst_rvalid_o) begin
                tp = cyc; pd = bus.mem_inst_rdata_o;
                bus.mem_inst_ren_i = 1'b0;
                done = 1'b1;
            end else if (dropped) begin
                if (!m_busy && !m_cool) done = 1'b1;
            end else begin
                if (cyc - t0 == drop_at) begin
                    bus.mem_inst_ren_i = 1'b0;
                    dropped = 1'b1;
                end
                if (cyc - t0 == chg_at) bus.mem_inst_araddr_i = a2;
            end
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL req_timeout addr=%0h got=no_completion want=completion", a);
        end
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, tp, p0, b0, a0, first_ar;
        logic [255:0] pd;
        logic [31:0] a, a2;
        int mode;
        for (int i = 0; i < 8; i++) cfg_gap[i] = 0;
        rst = 1'b1;
        bus.mem_inst_ren_i = 1'b0;
        bus.mem_inst_araddr_i = 32'h0;
        repeat (3) @(negedge clk);
        check("rst_araddr",  {224'd0, bus.araddr},  {224'd0, 32'h0});
        check("rst_arlen",   {248'd0, bus.arlen},   {248'd0, 8'd7});
        check("rst_arsize",  {253'd0, bus.arsize},  {253'd0, 3'b010});
        check("rst_arburst", {254'd0, bus.arburst}, {254'd0, 2'b01});
        check("rst_arid",    {252'd0, bus.arid},    {252'd0, 4'h0});
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // basic refill
        do_req(32'h1FC0_0024, -1, -1, 32'h0, t0, tp, pd);
        check("t1_latency", 256'(tp - t0), 256'd10);
        check("t1_araddr",  {224'd0, ar_addr_last}, {224'd0, 32'h1FC0_0020});
        check("t1_word7",   {224'd0, pd[255:224]}, {224'd0, 32'h8888_8888});
        check("t1_word0",   {224'd0, pd[31:0]},    {224'd0, 32'h1111_1111});
        repeat (2) @(negedge clk);

        // backpressure
        cfg_ar_wait = 3; cfg_gap[2] = 2; cfg_gap[5] = 2;
        do_req(32'h0000_2040, -1, -1, 32'h0, t0, tp, pd);
        check("t2_latency", 256'(tp - t0), 256'd17);
        cfg_ar_wait = 0; cfg_gap[2] = 0; cfg_gap[5] = 0;
        repeat (2) @(negedge clk);

        // cancel by dropping ren in R
        p0 = pulses; b0 = dut_beats;
        do_req(32'h0000_3000, 5, -1, 32'h0, t0, tp, pd);
        check("t3_beats",  256'(dut_beats - b0), 256'd8);
        check("t3_pulses", 256'(pulses - p0), 256'd0);
        do_req(32'h0000_0100, -1, -1, 32'h0, t0, tp, pd);
        check("t3_new_araddr", {224'd0, ar_addr_last}, {224'd0, 32'h0000_0100});

        // ren drops in the cycle of the final beat
        p0 = pulses;
        do_req(32'h0000_3400, 9, -1, 32'h0, t0, tp, pd);
        check("t3b_pulses", 256'(pulses - p0), 256'd0);

        // address change mid-burst
        cfg_pattern = 2; p0 = pulses; a0 = ar_rises;
        do_req(32'h0000_0040, -1, 4, 32'h0000_0080, t0, tp, pd);
        check("t4_ar_count", 256'(ar_rises - a0), 256'd2);
        check("t4_pulses",   256'(pulses - p0), 256'd1);
        check("t4_araddr",   {224'd0, ar_addr_last}, {224'd0, 32'h0000_0080});
        check("t4_word0",    {224'd0, pd[31:0]},    {224'd0, 32'h0000_0080});
        check("t4_word7",    {224'd0, pd[255:224]}, {224'd0, 32'h0000_009C});

        // early rlast after 3 beats: upper words keep stale contents
        cfg_pattern = 0; cfg_nbeats = 3;
        do_req(32'h0000_0300, -1, -1, 32'h0, t0, tp, pd);
        check("early_latency", 256'(tp - t0), 256'd5);
        check("early_word2",   {224'd0, pd[95:64]},  {224'd0, 32'h3333_3333});
        check("early_word3",   {224'd0, pd[127:96]}, {224'd0, 32'h0000_008C});
        cfg_nbeats = 8;

        // async reset in R after beat 3
        @(negedge clk);
        bus.mem_inst_ren_i = 1'b1; bus.mem_inst_araddr_i = 32'h0000_0400;
        b0 = dut_beats;
        for (int k = 0; k < 50 && (dut_beats - b0) < 3; k++) @(negedge clk);
        check("t5_beats_before_rst", 256'(dut_beats - b0), 256'd3);
        #2 rst = 1'b1;
        #1;
        check("t5_arvalid_async",  {255'd0, bus.arvalid}, 256'd0);
        check("t5_rready_async",   {255'd0, bus.rready},  256'd0);
        check("t5_rvalid_o_async", {255'd0, bus.mem_inst_rvalid_o}, 256'd0);
        bus.mem_inst_ren_i = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        do_req(32'h0000_0420, -1, -1, 32'h0, t0, tp, pd);
        check("t5_latency", 256'(tp - t0), 256'd10);

        // back-to-back misses
        repeat (2) @(negedge clk);
        p0 = pulses; a0 = ar_rises;
        do_req(32'h0000_1000, -1, -1, 32'h0, t0, tp, pd);
        first_ar = ar_rise_cyc;
        do_req(32'h0000_0200, -1, -1, 32'h0, t0, tp, pd);
        check("t6_ar_spacing", 256'(ar_rise_cyc - first_ar), 256'd11);
        check("t6_pulses",     256'(pulses - p0), 256'd2);
        check("t6_ar_count",   256'(ar_rises - a0), 256'd2);

        // randomized traffic checked by the model
        cfg_pattern = 1;
        for (int n = 0; n < 24; n++) begin
            cfg_ar_wait = $urandom_range(0, 3);
            for (int i = 0; i < 8; i++)
                cfg_gap[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
            a = $urandom;
            mode = $urandom_range(0, 3);
            if (mode == 0) begin
                do_req(a, $urandom_range(1, 12), -1, 32'h0, t0, tp, pd);
            end else if (mode == 1) begin
                a2 = a ^ 32'h0000_0020;
                do_req(a, -1, $urandom_range(1, 10), a2, t0, tp, pd);
            end else if (mode == 2) begin
                a2 = {a[31:5], ~a[4:0]};
                do_req(a, -1, $urandom_range(1, 10), a2, t0, tp, pd);
            end else begin
                do_req(a, -1, -1, 32'h0, t0, tp, pd);
            end
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
